clk_div_ctrl: RTL and testbench

//   Run-time controller for the slow-clock timebase. It holds a programmable divide

---
 rtl/clk_div_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Slow-clock timebase: programmable divider with start/stop/one-shot sequencing.
// Ratio updates are double-buffered and applied only on a period boundary.
module clk_div_ctrl #(
    parameter int unsigned          CNT_W       = 32,
    parameter logic [CNT_W-1:0]     DEFAULT_DIV = CNT_W'(199999999)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_oneshot_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             tick_o,
    output logic             clk_div_o
);

    // state | meaning
    // IDLE  | counter parked at 0, outputs low, config loads straight into the active set
    // RUN   | counting up to div_act; config goes to the shadow until the next boundary
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;

    logic [CNT_W-1:0]   ctr_q, ctr_d;
    logic [CNT_W-1:0]   div_act_q, div_act_d;
    logic               oneshot_act_q, oneshot_act_d;
    logic [CNT_W-1:0]   div_shd_q, div_shd_d;
    logic               oneshot_shd_q, oneshot_shd_d;
    logic               pend_q, pend_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               tick_q, tick_d;
    logic               clk_div_q, clk_div_d;

    logic               cfg_xfer;
    logic               at_tc;

    assign cfg_xfer = cfg_valid_i && cfg_ready_q;
    assign at_tc    = (ctr_q == div_act_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (at_tc && oneshot_act_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctr_d         = ctr_q;
        div_act_d     = div_act_q;
        oneshot_act_d = oneshot_act_q;
        div_shd_d     = div_shd_q;
        oneshot_shd_d = oneshot_shd_q;
        pend_d        = pend_q;
        cfg_ready_d   = cfg_ready_q;
        tick_d        = 1'b0;
        clk_div_d     = clk_div_q;

        case (state_q)
            ST_IDLE: begin
                ctr_d     = '0;
                clk_div_d = 1'b0;
                if (cfg_xfer) begin
                    div_act_d     = cfg_div_i;
                    oneshot_act_d = cfg_oneshot_i;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    // Leaving RUN: a waiting shadow value becomes active immediately.
                    ctr_d     = '0;
                    clk_div_d = 1'b0;
                    if (pend_q) begin
                        div_act_d     = div_shd_q;
                        oneshot_act_d = oneshot_shd_q;
                        pend_d        = 1'b0;
                        cfg_ready_d   = 1'b1;
                    end
                    if (cfg_xfer) begin
                        div_act_d     = cfg_div_i;
                        oneshot_act_d = cfg_oneshot_i;
                    end
                end else begin
                    if (at_tc) begin
                        ctr_d     = '0;
                        tick_d    = 1'b1;
                        clk_div_d = ~clk_div_q;
                        if (pend_q) begin
                            div_act_d     = div_shd_q;
                            oneshot_act_d = oneshot_shd_q;
                            pend_d        = 1'b0;
                            cfg_ready_d   = 1'b1;
                        end
                    end else begin
                        ctr_d = ctr_q + CNT_W'(1);
                    end
                    // A one-shot boundary returns to IDLE, so a value taken there goes active
                    // directly rather than waiting for a boundary that will never come.
                    if (cfg_xfer) begin
                        if (at_tc && oneshot_act_q) begin
                            div_act_d     = cfg_div_i;
                            oneshot_act_d = cfg_oneshot_i;
                        end else begin
                            div_shd_d     = cfg_div_i;
                            oneshot_shd_d = cfg_oneshot_i;
                            pend_d        = 1'b1;
                            cfg_ready_d   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                ctr_d     = '0;
                clk_div_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr_q         <= '0;
            div_act_q     <= DEFAULT_DIV;
            oneshot_act_q <= 1'b0;
            div_shd_q     <= '0;
            oneshot_shd_q <= 1'b0;
            pend_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
            tick_q        <= 1'b0;
            clk_div_q     <= 1'b0;
        end else begin
            ctr_q         <= ctr_d;
            div_act_q     <= div_act_d;
            oneshot_act_q <= oneshot_act_d;
            div_shd_q     <= div_shd_d;
            oneshot_shd_q <= oneshot_shd_d;
            pend_q        <= pend_d;
            cfg_ready_q   <= cfg_ready_d;
            tick_q        <= tick_d;
            clk_div_q     <= clk_div_d;
        end
    end

    assign busy_o      = (state_q == ST_RUN);
    assign cfg_ready_o = cfg_ready_q;
    assign tick_o      = tick_q;
    assign clk_div_o   = clk_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, all checked
// against a period-level reference model.
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W   = 32;
    localparam logic [31:0] DEF_DIV = 32'd9;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [CNT_W-1:0]  cfg_div_i;
    logic              cfg_oneshot_i;
    logic              start_i;
    logic              stop_i;
    logic              busy_o;
    logic              tick_o;
    logic              clk_div_o;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_div_i     (cfg_div_i),
        .cfg_oneshot_i (cfg_oneshot_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .busy_o        (busy_o),
        .tick_o        (tick_o),
        .clk_div_o     (clk_div_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: where we are inside the current period, the ratio in force,
    // and at most one queued ratio waiting for the period boundary.
    bit          m_running = 0;
    logic [31:0] m_elapsed = 0;
    logic [31:0] m_ratio   = DEF_DIV;
    bit          m_single  = 0;
    bit          m_queued  = 0;
    logic [31:0] m_q_ratio = 0;
    bit          m_q_single = 0;
    bit          m_ready   = 1;
    bit          m_tick    = 0;
    bit          m_wave    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [31:0] d, input bit o,
                              input bit st, input bit sp);
        bit accepted;
        bit boundary;
        bit was_single;
        accepted = v && m_ready;
        if (r) begin
            m_running = 0; m_elapsed = 0; m_ratio = DEF_DIV; m_single = 0;
            m_queued = 0; m_ready = 1; m_tick = 0; m_wave = 0;
            return;
        end
        m_tick = 0;
        if (!m_running) begin
            m_wave = 0;
            if (accepted) begin m_ratio = d; m_single = o; end
            if (st && !sp) begin m_running = 1; m_elapsed = 0; end
        end else if (sp) begin
            m_running = 0; m_elapsed = 0; m_wave = 0;
            if (m_queued) begin
                m_ratio = m_q_ratio; m_single = m_q_single; m_queued = 0; m_ready = 1;
            end
            if (accepted) begin m_ratio = d; m_single = o; end
        end else begin
            boundary   = (m_elapsed == m_ratio);
            was_single = m_single;
            if (boundary) begin
                m_tick = 1; m_wave = !m_wave; m_elapsed = 0;
                if (was_single) m_running = 0;
                if (m_queued) begin
                    m_ratio = m_q_ratio; m_single = m_q_single; m_queued = 0; m_ready = 1;
                end
            end else begin
                m_elapsed = m_elapsed + 1;
            end
            if (accepted) begin
                if (boundary && was_single) begin
                    m_ratio = d; m_single = o;
                end else begin
                    m_q_ratio = d; m_q_single = o; m_queued = 1; m_ready = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [31:0] d, input bit o,
                         input bit st, input bit sp);
        rst_i = r; cfg_valid_i = v; cfg_div_i = d; cfg_oneshot_i = o;
        start_i = st; stop_i = sp;
        @(posedge clk_i);
        model_step(r, v, d, o, st, sp);
        #1;
        check("cfg_ready", {31'd0, cfg_ready_o}, {31'd0, m_ready});
        check("busy",      {31'd0, busy_o},      {31'd0, m_running});
        check("tick",      {31'd0, tick_o},      {31'd0, m_tick});
        check("clk_div",   {31'd0, clk_div_o},   {31'd0, m_wave});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Runs n idle cycles; reports the first cycle index (1-based) with tick and the tick count.
    task automatic watch(input int n, output int first, output int count);
        first = -1; count = 0;
        for (int i = 1; i <= n; i++) begin
            idle();
            if (tick_o === 1'b1) begin
                if (first < 0) first = i;
                count++;
            end
        end
    endtask

    initial begin
        int  first, count;
        bit  v_hold;
        logic [31:0] v_div;
        bit  v_os, rdy;

        rst_i = 1; cfg_valid_i = 0; cfg_div_i = 0; cfg_oneshot_i = 0;
        start_i = 0; stop_i = 0;

        // Reset and quiet idle
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
        check("rst_busy",  {31'd0, busy_o},      32'd0);
        idle(); idle();
        check("idle_tick", {31'd0, tick_o},      32'd0);
        check("idle_clkdiv", {31'd0, clk_div_o}, 32'd0);

        // Free-running DIV=3
        cycle(0, 1, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        watch(12, first, count);
        check("div3_first_tick", first, 4);
        check("div3_tick_count", count, 3);

        // Mid-period ratio change to 1
        cycle(0, 1, 1, 0, 0, 0);
        check("upd_ready_low", {31'd0, cfg_ready_o}, 32'd0);
        watch(8, first, count);
        check("upd_first_tick", first, 3);
        check("upd_tick_count", count, 3);
        check("upd_ready_high", {31'd0, cfg_ready_o}, 32'd1);

        // One-shot DIV=2
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 2, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        watch(8, first, count);
        check("os_first_tick", first, 3);
        check("os_tick_count", count, 1);
        check("os_busy_end", {31'd0, busy_o}, 32'd0);

        // Stop exactly at terminal count, then start&&stop in IDLE
        cycle(0, 1, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle(); idle();
        cycle(0, 0, 0, 0, 0, 1);
        check("stop_tc_tick", {31'd0, tick_o}, 32'd0);
        check("stop_tc_busy", {31'd0, busy_o}, 32'd0);
        cycle(0, 0, 0, 0, 1, 1);
        check("startstop_busy", {31'd0, busy_o}, 32'd0);

        // Stop with an update pending: shadow becomes active
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 5, 0, 0, 0);
        check("pend_ready_low", {31'd0, cfg_ready_o}, 32'd0);
        cycle(0, 0, 0, 0, 0, 1);
        check("pend_stop_ready", {31'd0, cfg_ready_o}, 32'd1);
        cycle(0, 0, 0, 0, 1, 0);
        watch(7, first, count);
        check("pend_stop_first_tick", first, 6);
        cycle(0, 0, 0, 0, 0, 1);

        // DIV=0: tick every cycle
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        watch(6, first, count);
        check("div0_tick_count", count, 6);

        // Reset mid-run with an update pending
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 2, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_run_ready", {31'd0, cfg_ready_o}, 32'd1);
        check("rst_run_busy",  {31'd0, busy_o},      32'd0);
        cycle(0, 0, 0, 0, 1, 0);
        watch(12, first, count);
        check("rst_default_first_tick", first, 10);
        cycle(0, 0, 0, 0, 0, 1);

        // Random traffic; the master holds cfg_valid until accepted
        v_hold = 0; v_div = 0; v_os = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!v_hold && $urandom_range(0, 9) == 0) begin
                v_hold = 1;
                v_div  = $urandom_range(0, 6);
                v_os   = ($urandom_range(0, 4) == 0);
            end
            rdy = cfg_ready_o;
            cycle(($urandom_range(0, 299) == 0), v_hold, v_div, v_os,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
            if (v_hold && rdy) v_hold = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
